// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Optional subtract support is selected with SERIAL_ADD_SUB_EN.
package serial_adder_pkg;

  localparam int SA_NUM_BITS = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;

  // Two's-complement overflow: operands agree in sign and the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand and result handshakes of the bit-serial adder.
// The sub signal exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int NUM_BITS = SA_NUM_BITS
) ();

  logic                in_valid;
  logic                in_ready;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic                sub;
`endif
  logic                out_valid;
  logic                out_ready;
  logic [NUM_BITS-1:0] sum;
  logic                carry_out;
  logic                overflow;

`ifdef SERIAL_ADD_SUB_EN
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
`endif

endinterface

// File: rtl/adder_1bit.sv
// Single full-adder cell used as the serial datapath.
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial NUM_BITS adder: operands are accepted in parallel, fed LSB-first
// through one full-adder cell, and the result is returned with carry and
// signed overflow. Define SERIAL_ADD_SUB_EN to add the sub port (A + ~B + 1).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int NUM_BITS = SA_NUM_BITS
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int                CNT_W = $clog2(NUM_BITS);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_BITS - 1);

  sa_state_t           state_q, state_d;
  logic [NUM_BITS-1:0] a_sr_q, a_sr_d;
  logic [NUM_BITS-1:0] b_sr_q, b_sr_d;
  logic [NUM_BITS-1:0] sum_sr_q, sum_sr_d;
  logic                carry_q, carry_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                a_msb_q, a_msb_d;
  logic                b_msb_q, b_msb_d;
  logic [NUM_BITS-1:0] sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;

  logic                sub_eff;
  logic [NUM_BITS-1:0] b_eff;
  logic                fa_sum;
  logic                fa_cout;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_eff = bus.sub;
`else
  assign sub_eff = 1'b0;
`endif

  // Subtraction inverts B here; the +1 enters through the initial carry.
  assign b_eff = sub_eff ? ~bus.b : bus.b;

  adder_1bit u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state and datapath sequencing for IDLE -> SHIFT -> DONE.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    count_d  = count_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sr_d  = bus.a;
          b_sr_d  = b_eff;
          carry_d = sub_eff;
          a_msb_d = bus.a[NUM_BITS-1];
          b_msb_d = b_eff[NUM_BITS-1];
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sum_sr_d = {fa_sum, sum_sr_q[NUM_BITS-1:1]};
        carry_d  = fa_cout;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == LAST) begin
          // Result registers update only on completion so they stay stable
          // while the next operation is in flight.
          sum_d   = sum_sr_d;
          cout_d  = fa_cout;
          ovf_d   = signed_ovf(a_msb_q, b_msb_q, fa_sum);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

  // Flag unknown operands at the accept edge; the operation still proceeds.
  always @(posedge clk) begin
    if (!rst && (state_q == IDLE) && bus.in_valid) begin
      assert (!$isunknown({bus.a, bus.b}))
      else $error("serial_adder_ctrl: X/Z on operands at accept");
    end
  end

endmodule
